// File: rtl/display_arb_pkg.sv
// Shared types and sizing helpers for the display share arbiter.
package display_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_DWELL} arb_state_t;

  localparam int DWELL_DEFAULT   = 12_000_000;
  localparam int DWELL_W_DEFAULT = 24;

  // Owner / pointer width; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import display_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    sum;

  always_comb begin
    any = 1'b0;
    idx = '0;
    sum = '0;
    dbl = {req, req};
    rot = N'(dbl >> ptr);
    // Scan downwards so the smallest offset from ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (IW + 1)'(k);
        if (sum >= (IW + 1)'(N)) begin
          sum = sum - (IW + 1)'(N);
        end
        idx = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/display_share_arbiter.sv
// Round-robin sharing of one multiplexed 7-segment number bus with a dwell time.
// Optional requester-0 preemption is enabled with DISPLAY_ARB_PREEMPT_EN.
module display_share_arbiter
  import display_arb_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int N_DIG   = 4,
  parameter  int DWELL   = DWELL_DEFAULT,
  parameter  int DWELL_W = DWELL_W_DEFAULT,
  localparam int NW      = N_DIG * 4,
  localparam int IW      = idx_width(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*NW-1:0]   req_number,
  output logic [N_REQ-1:0]      req_ready,
  output logic [NW-1:0]         number,
  output logic [IW-1:0]         owner,
  output logic                  busy
);

  localparam int               DWELL_EFF = (DWELL < 1) ? 1 : DWELL;
  localparam logic [DWELL_W-1:0] CNT_LOAD = DWELL_W'(DWELL_EFF - 1);

  arb_state_t         state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [NW-1:0]      number_q, number_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [N_REQ-1:0]   ready_q, ready_d;

  logic [NW-1:0]      slice [N_REQ];
  logic [IW-1:0]      pick_ptr;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               preempt_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign slice[gi] = req_number[gi*NW +: NW];
    end
  endgenerate

`ifdef DISPLAY_ARB_PREEMPT_EN
  logic preempt_q, preempt_d;

  assign preempt_hit = (state_q == ARB_DWELL) && req_valid[0] && (owner_q != '0);
  assign pick_ptr    = preempt_q ? '0 : ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) preempt_q <= 1'b0;
    else       preempt_q <= preempt_d;
  end

  // The forced-zero pointer applies to exactly one IDLE cycle after an abort.
  always_comb begin
    preempt_d = preempt_q;
    if (state_q == ARB_IDLE) preempt_d = 1'b0;
    if (preempt_hit)         preempt_d = 1'b1;
  end
`else
  assign preempt_hit = 1'b0;
  assign pick_ptr    = ptr_q;
`endif

  rr_pick #(.N(N_REQ)) u_pick (
    .req (req_valid),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      number_q <= '0;
      owner_q  <= '0;
      ready_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      number_q <= number_d;
      owner_q  <= owner_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (pick_any) state_d = ARB_DWELL;
      ARB_DWELL: if (cnt_q == '0 || preempt_hit) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    number_d = number_q;
    owner_d  = owner_q;
    ready_d  = '0;
    if (state_q == ARB_IDLE) begin
      if (pick_any) begin
        number_d = slice[pick_idx];
        owner_d  = pick_idx;
        ready_d  = N_REQ'(1) << pick_idx;
        cnt_d    = CNT_LOAD;
        ptr_d    = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  assign req_ready = ready_q;
  assign number    = number_q;
  assign owner     = owner_q;
  assign busy      = (state_q == ARB_DWELL);

endmodule
